// File: rtl/eth_mdio_master_pkg.sv
// rtl/eth_mdio_master_pkg.sv - shared types, frame constants and frame builder for the MDIO master
package eth_mdio_master_pkg;

    typedef enum logic [1:0] {RST_HOLD, IDLE, SHIFT, DONE} mdio_state_e;

    localparam logic [1:0] MDIO_ST = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] TA_WR   = 2'b10;

    localparam int PREAMBLE_LEN = 32;
    localparam int TA_IDX       = 46;
    localparam int DATA_IDX     = 48;
    localparam int FRAME_LEN    = 64;
    localparam int BIT_W        = $clog2(FRAME_LEN);

    // Bit 0 of the frame sits in the MSB; read frames carry 1s where the line is released.
    function automatic logic [FRAME_LEN-1:0] mdio_frame(input logic        wr,
                                                        input logic [4:0]  phy,
                                                        input logic [4:0]  regad,
                                                        input logic [15:0] wdata);
        mdio_frame = {{PREAMBLE_LEN{1'b1}}, MDIO_ST, (wr ? OP_WR : OP_RD), phy, regad,
                      (wr ? TA_WR : 2'b11), (wr ? wdata : 16'hFFFF)};
    endfunction

endpackage

// File: rtl/eth_mdio_master_if.sv
// rtl/eth_mdio_master_if.sv - request/response port bundle of the MDIO master
interface eth_mdio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [4:0]  req_phy_addr;
    logic [4:0]  req_reg_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/eth_mdio_master_clk_div.sv
// rtl/eth_mdio_master_clk_div.sv - MDC generator with one-cycle pulses ahead of each MDC edge
module mdio_clk_div #(
    parameter int CLK_DIV = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clear_i,
    output logic mdc_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mdc_q, mdc_d;
    logic          half_end;

    assign half_end = run_i && !clear_i && (cnt_q == LAST);

    // Ticks fire in the last cycle of a half-period, so the edge that moves MDC also acts on them.
    assign rise_tick_o = half_end && !mdc_q;
    assign fall_tick_o = half_end && mdc_q;
    assign mdc_o       = mdc_q;

    always_comb begin
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (clear_i || !run_i) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (half_end) begin
            cnt_d = '0;
            mdc_d = ~mdc_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end
endmodule

// File: rtl/eth_mdio_master.sv
// rtl/eth_mdio_master.sv - PHY reset sequencer and clause-22 MDIO read/write frame engine
module eth_mdio_master
    import eth_mdio_master_pkg::*;
#(
    parameter int CLK_DIV        = 20,
    parameter int PHY_RST_CYCLES = 1_000_000
) (
    input  logic               sys_clk,
    input  logic               rst,
    eth_mdio_master_if.slave   req_if,
    output logic               busy,
    output logic               eth_mdio_mdc,
    output logic               mdio_o,
    input  logic               mdio_i,
    output logic               mdio_t,
    output logic               eth_rst_n
);
    localparam int               RW       = (PHY_RST_CYCLES > 1) ? $clog2(PHY_RST_CYCLES) : 1;
    localparam logic [RW-1:0]    RST_LAST = RW'(PHY_RST_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 1);
    localparam logic [BIT_W-1:0] TA_PREV  = BIT_W'(TA_IDX - 1);
    localparam logic [BIT_W-1:0] DATA_BIT = BIT_W'(DATA_IDX);

    mdio_state_e          state_q;
    logic [RW-1:0]        rst_cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [FRAME_LEN-1:0] frame_q;
    logic                 write_q;
    logic [15:0]          rd_sh_q;
    logic [15:0]          rdata_q;
    logic                 ready_q, resp_valid_q, busy_q;
    logic                 mdio_o_q, mdio_t_q, eth_rst_n_q;

    logic                 run, clear, mdc, rise_tick, fall_tick;
    logic [FRAME_LEN-1:0] req_frame;

    assign run       = (state_q == SHIFT);
    assign clear     = (state_q == IDLE) && req_if.req_valid;
    assign req_frame = mdio_frame(req_if.req_write, req_if.req_phy_addr,
                                  req_if.req_reg_addr, req_if.req_wdata);

    mdio_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk_i       (sys_clk),
        .rst_i       (rst),
        .run_i       (run),
        .clear_i     (clear),
        .mdc_o       (mdc),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= RST_HOLD;
            rst_cnt_q    <= '0;
            bit_q        <= '0;
            frame_q      <= '0;
            write_q      <= 1'b0;
            rd_sh_q      <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            mdio_o_q     <= 1'b1;
            mdio_t_q     <= 1'b1;
            eth_rst_n_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                RST_HOLD: begin
                    if (rst_cnt_q == RST_LAST) begin
                        eth_rst_n_q <= 1'b1;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (req_if.req_valid) begin
                        frame_q  <= req_frame;
                        write_q  <= req_if.req_write;
                        bit_q    <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        mdio_o_q <= req_frame[FRAME_LEN-1];
                        mdio_t_q <= 1'b0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise_tick && !write_q && (bit_q >= DATA_BIT)) begin
                        rd_sh_q <= {rd_sh_q[14:0], mdio_i};
                    end
                    // Bit boundaries coincide with MDC falling; the next bit's value and direction load here.
                    if (fall_tick) begin
                        if (bit_q == LAST_BIT) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= write_q ? 16'h0000 : rd_sh_q;
                            mdio_o_q     <= 1'b1;
                            mdio_t_q     <= 1'b1;
                        end else begin
                            bit_q    <= bit_q + 1'b1;
                            frame_q  <= frame_q << 1;
                            mdio_o_q <= frame_q[FRAME_LEN-2];
                            mdio_t_q <= !write_q && (bit_q >= TA_PREV);
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= RST_HOLD;
            endcase
        end
    end

    assign req_if.req_ready  = ready_q;
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_rdata = rdata_q;
    assign busy              = busy_q;
    assign eth_mdio_mdc      = mdc;
    assign mdio_o            = mdio_o_q;
    assign mdio_t            = mdio_t_q;
    assign eth_rst_n         = eth_rst_n_q;
endmodule

// File: tb/tb_eth_mdio_master.sv
// tb/tb_eth_mdio_master.sv - scoreboard bench with a serial PHY model for eth_mdio_master
module tb_eth_mdio_master;
    localparam int CLK_DIV        = 4;
    localparam int PHY_RST_CYCLES = 16;
    localparam int FRAME_CYC      = 128 * CLK_DIV;

    typedef struct {
        logic        wr;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [15:0] wd;
    } req_t;

    typedef struct {
        logic [15:0] rdata;
        int          hs;
    } resp_t;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    logic busy, mdc, mdio_o, mdio_i, mdio_t, eth_rst_n;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    req_t        frame_q[$];
    resp_t       resp_q[$];
    logic [15:0] phy_q[$];

    eth_mdio_master_if bus();

    eth_mdio_master #(.CLK_DIV(CLK_DIV), .PHY_RST_CYCLES(PHY_RST_CYCLES)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .req_if       (bus.slave),
        .busy         (busy),
        .eth_mdio_mdc (mdc),
        .mdio_o       (mdio_o),
        .mdio_i       (mdio_i),
        .mdio_t       (mdio_t),
        .eth_rst_n    (eth_rst_n)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference frame: bit index i of the wire stream lives at f[63-i].
    function automatic logic [63:0] put(input logic [63:0] f, input int idx, input int len, input logic [15:0] v);
        for (int k = 0; k < len; k++) f[63-idx-k] = v[len-1-k];
        return f;
    endfunction

    function automatic logic [63:0] model_frame(input req_t r);
        logic [63:0] f;
        f = '1;
        f = put(f, 32, 2, 16'h1);
        f = put(f, 34, 2, r.wr ? 16'h1 : 16'h2);
        f = put(f, 36, 5, {11'h0, r.pa});
        f = put(f, 41, 5, {11'h0, r.ra});
        if (r.wr) begin
            f = put(f, 46, 2, 16'h2);
            f = put(f, 48, 16, r.wd);
        end
        return f;
    endfunction

    function automatic logic [63:0] model_t(input logic wr);
        logic [63:0] t;
        t = '0;
        for (int i = 46; i < 64; i++) t[63-i] = !wr;
        return t;
    endfunction

    // Serial side: decodes the frame at MDC rising edges, acts as the PHY on reads, checks MDC timing.
    initial begin : phy_mon
        logic        prev_mdc, prev_o, rd_act;
        logic [63:0] cap_o, cap_t, exp_t;
        logic [17:0] seq;
        int          nb, prev_rise, last_chg, per_err, stab_err;
        req_t        r;
        prev_mdc = 1'b0; prev_o = 1'b1; rd_act = 1'b0; seq = '1;
        cap_o = '0; cap_t = '0; nb = 0;
        prev_rise = -1000; last_chg = -1000; per_err = 0; stab_err = 0;
        mdio_i = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (rst || !busy) begin
                nb = 0; rd_act = 1'b0; per_err = 0; stab_err = 0;
                prev_rise = -1000; last_chg = -1000; mdio_i = 1'b1;
            end else begin
                if (mdio_o !== prev_o) begin
                    if (cyc - prev_rise < CLK_DIV) stab_err++;
                    last_chg = cyc;
                end
                if (mdc && !prev_mdc) begin
                    if (cyc - last_chg < CLK_DIV) stab_err++;
                    if (prev_rise >= 0 && cyc - prev_rise != 2 * CLK_DIV) per_err++;
                    prev_rise = cyc;
                    if (nb < 64) begin
                        cap_o[63-nb] = mdio_o;
                        cap_t[63-nb] = mdio_t;
                    end
                    nb++;
                    if (nb == 36 && cap_o[29:28] == 2'b10) begin
                        rd_act = 1'b1;
                        if (phy_q.size() == 0) begin
                            fail_now("phy_data_missing");
                            seq = {2'b10, 16'h0000};
                        end else begin
                            seq = {2'b10, phy_q.pop_front()};
                        end
                    end
                    if (nb == 64) begin
                        if (frame_q.size() == 0) begin
                            fail_now("frame_unexpected");
                        end else begin
                            r     = frame_q.pop_front();
                            exp_t = model_t(r.wr);
                            chk("frame_bits", cap_o & ~exp_t, model_frame(r) & ~exp_t);
                            chk("frame_mdio_t", cap_t, exp_t);
                            chk("mdc_period", 64'(per_err), 64'd0);
                            chk("mdio_stable", 64'(stab_err), 64'd0);
                        end
                    end
                end
                if (!mdc && prev_mdc) begin
                    if (cyc - prev_rise != CLK_DIV) per_err++;
                    mdio_i = (rd_act && nb >= 46 && nb < 64) ? seq[17-(nb-46)] : 1'b1;
                end
            end
            prev_mdc = mdc;
            prev_o   = mdio_o;
        end
    end

    initial begin : resp_mon
        resp_t e;
        forever begin
            @(negedge sys_clk);
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) begin
                    fail_now("resp_unexpected");
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
                    chk("resp_latency", 64'(cyc - e.hs), 64'(FRAME_CYC + 1));
                end
                @(negedge sys_clk);
                chk("resp_pulse_ready", {62'h0, bus.resp_valid, bus.req_ready}, 64'h1);
            end
        end
    end

    task automatic send(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input logic [15:0] pd,
                        input bit keep, input bit scramble, output int hs);
        int    n;
        req_t  r;
        resp_t e;
        n = 0;
        hs = -1;
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_phy_addr = pa;
        bus.req_reg_addr = ra;
        bus.req_wdata    = wd;
        while (!bus.req_ready) begin
            if (n++ > 3 * FRAME_CYC) begin
                fail_now("handshake_timeout");
                bus.req_valid = 1'b0;
                return;
            end
            @(negedge sys_clk);
            if (scramble) begin
                bus.req_write    = 1'($urandom);
                bus.req_phy_addr = 5'($urandom);
                bus.req_reg_addr = 5'($urandom);
                bus.req_wdata    = 16'($urandom);
            end
        end
        r.wr = bus.req_write; r.pa = bus.req_phy_addr; r.ra = bus.req_reg_addr; r.wd = bus.req_wdata;
        hs = cyc;
        e.hs = cyc;
        e.rdata = r.wr ? 16'h0000 : pd;
        if (!r.wr) phy_q.push_back(pd);
        frame_q.push_back(r);
        resp_q.push_back(e);
        @(negedge sys_clk);
        chk("ready_drop_busy", {62'h0, bus.req_ready, busy}, 64'h1);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.req_ready && n < 3 * FRAME_CYC) begin
            n++;
            @(negedge sys_clk);
        end
        if (!bus.req_ready) fail_now("idle_timeout");
    endtask

    task automatic rst_release();
        int   n;
        logic rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        rst = 1'b0;
        while (!eth_rst_n && n < PHY_RST_CYCLES + 50) begin
            if (bus.req_ready) rdy_seen = 1'b1;
            n++;
            @(negedge sys_clk);
        end
        chk("rst_hold_len", 64'(n), 64'(PHY_RST_CYCLES));
        chk("ready_during_hold", {63'h0, rdy_seen}, 64'h0);
        chk("release_state", {61'h0, eth_rst_n, bus.req_ready, busy}, 64'h6);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int hs;
        bus.req_valid = 1'b0; bus.req_write = 1'b0;
        bus.req_phy_addr = '0; bus.req_reg_addr = '0; bus.req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("reset_outputs",
            {40'h0, mdc, mdio_o, mdio_t, eth_rst_n, bus.req_ready, bus.resp_valid, bus.resp_rdata, busy},
            {40'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1});
        rst_release();

        send(1'b1, 5'd1, 5'h00, 16'h8000, 16'h0000, 1'b0, 1'b0, hs);
        wait_idle();
        send(1'b0, 5'd1, 5'h02, 16'h0000, 16'h0022, 1'b0, 1'b0, hs);
        wait_idle();

        send(1'b1, 5'd3, 5'h04, 16'h1234, 16'h0000, 1'b1, 1'b0, hs);
        send(1'b0, 5'd9, 5'h11, 16'hAAAA, 16'($urandom), 1'b0, 1'b1, hs);
        wait_idle();

        repeat (6) begin
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            send(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0, hs);
        end
        wait_idle();

        send(1'b0, 5'h1f, 5'h01, 16'h0000, 16'hBEEF, 1'b0, 1'b0, hs);
        while (cyc < hs + 1 + 2 * CLK_DIV * 50 + CLK_DIV) @(negedge sys_clk);
        rst = 1'b1;
        void'(frame_q.pop_back());
        void'(resp_q.pop_back());
        @(negedge sys_clk);
        chk("abort_outputs",
            {58'h0, mdio_t, eth_rst_n, mdc, busy, bus.req_ready, bus.resp_valid},
            {58'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        repeat (2) @(negedge sys_clk);
        rst_release();

        send(1'b0, 5'($urandom), 5'($urandom), 16'h0000, 16'($urandom), 1'b0, 1'b0, hs);
        wait_idle();
        send(1'b1, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0000, 1'b0, 1'b0, hs);
        wait_idle();
        repeat (4) @(negedge sys_clk);

        chk("resp_queue_empty", 64'(resp_q.size()), 64'd0);
        chk("frame_queue_empty", 64'(frame_q.size()), 64'd0);
        chk("phy_queue_empty", 64'(phy_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
